// File: rtl/mp1000_pkg.sv
// Shared definitions for the MP1000 ROM download path.
package mp1000_pkg;

   // Loader sequencing: wait for a download, accept bytes, flush, publish results.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Default ioctl_index values used by the MiSTer menu for this core.
   localparam logic [7:0]  BIOS_INDEX = 8'd0;
   localparam logic [7:0]  CART_INDEX = 8'd1;

   // Smallest cartridge mirror mask: images up to 2 KB mirror across 2 KB.
   localparam logic [10:0] MIN_MASK   = 11'h7FF;

endpackage

// File: rtl/mp1000_loader_fifo.sv
// Two-entry first-word-fall-through FIFO between the ioctl stream and the ROM port.
module mp1000_loader_fifo #(
   parameter int WIDTH = 22
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic [1:0]       o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO or a pop from an empty one is ignored.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage.
   // NOTE: storage is deliberately not reset; the reset count marks every entry invalid.
   always_ff @(posedge clk_sys) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_full     = (r_count == 2'd2);
   assign o_empty    = (r_count == 2'd0);

endmodule

// File: rtl/mp1000_cart_loader.sv
// Consumes the hps_io ioctl download stream and writes BIOS / cartridge ROM.
module mp1000_cart_loader #(
   parameter int         CART_AW    = 14,
   parameter int         BIOS_AW    = 11,
   parameter logic [7:0] BIOS_INDEX = mp1000_pkg::BIOS_INDEX,
   parameter logic [7:0] CART_INDEX = mp1000_pkg::CART_INDEX
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               ioctl_download,
   input  logic [7:0]         ioctl_index,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   output logic               ioctl_wait,
   output logic               mem_we,
   output logic               mem_sel,
   output logic [CART_AW-1:0] mem_addr,
   output logic [7:0]         mem_data,
   input  logic               mem_ack,
   output logic               core_hold,
   output logic               cart_loaded,
   output logic [CART_AW:0]   cart_size,
   output logic [CART_AW-1:0] cart_mask,
   output logic               overflow
);

   import mp1000_pkg::*;

   localparam int          FW         = CART_AW + 8;
   localparam int          SW         = CART_AW + 1;
   localparam int          LW         = $clog2(CART_AW + 1);
   localparam logic [24:0] CART_BYTES = 25'(1) << CART_AW;
   localparam logic [24:0] BIOS_BYTES = 25'(1) << BIOS_AW;

   state_t             r_state, w_state_nxt;
   logic               r_dl_q;
   logic               r_mem_we, r_mem_sel, r_cart_loaded, r_overflow;
   logic [CART_AW-1:0] r_mem_addr, r_cart_mask;
   logic [7:0]         r_mem_data;
   logic [SW-1:0]      r_cart_size;

   logic               w_dl_rise, w_dl_fall, w_index_ok, w_start;
   logic               w_in_range, w_wr_load, w_push, w_drop, w_pop;
   logic               w_core_hold;
   logic [CART_AW-1:0] w_wr_addr;
   logic [SW-1:0]      w_addr_p1;
   logic [FW-1:0]      w_fifo_head;
   logic [1:0]         w_fifo_count;
   logic               w_fifo_full, w_fifo_empty;
   logic [CART_AW-1:0] w_size_m1, w_mask_raw, w_mask;
   logic [LW-1:0]      w_lead;

   // Download window edges and acceptance of a new download.
   assign w_dl_rise  = ioctl_download && !r_dl_q;
   assign w_dl_fall  = !ioctl_download && r_dl_q;
   assign w_index_ok = (ioctl_index == BIOS_INDEX) || (ioctl_index == CART_INDEX);
   assign w_start    = (r_state == ST_IDLE) && w_dl_rise && w_index_ok;

   // Incoming byte qualification against the size of the selected ROM.
   assign w_in_range = r_mem_sel ? (ioctl_addr < CART_BYTES) : (ioctl_addr < BIOS_BYTES);
   assign w_wr_addr  = r_mem_sel ? ioctl_addr[CART_AW-1:0]
                                 : CART_AW'(ioctl_addr[BIOS_AW-1:0]);
   assign w_wr_load  = (r_state == ST_LOAD) && ioctl_wr;
   assign w_push     = w_wr_load && w_in_range && !w_fifo_full;
   assign w_drop     = w_wr_load && !(w_in_range && !w_fifo_full);
   assign w_addr_p1  = ioctl_addr[CART_AW:0] + SW'(1);

   // The ROM port takes a new byte only when no write is outstanding.
   assign w_pop      = !r_mem_we && !w_fifo_empty;

   mp1000_loader_fifo #(.WIDTH(FW)) u_fifo (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_push_data ({w_wr_addr, ioctl_dout}),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_head),
      .o_count     (w_fifo_count),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   // State register and download-window edge detector.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_dl_q  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dl_q  <= ioctl_download;
      end
   end

   // Next-state and core-hold decode.
   // NOTE: defaults come first so no path through the block can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_core_hold = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE:   if (w_start)                        w_state_nxt = ST_LOAD;
         ST_LOAD:   if (w_dl_fall)                      w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (w_fifo_empty && !r_mem_we)      w_state_nxt = ST_FINISH;
         ST_FINISH:                                     w_state_nxt = ST_IDLE;
         default:                                       w_state_nxt = ST_IDLE;
      endcase
   end

   // Leading-one encoder on size-1: the mirror mask is all ones up to and including that bit.
   always_comb begin
      w_size_m1 = r_cart_size[CART_AW-1:0] - CART_AW'(1);
      w_lead    = '0;
      for (int i = 0; i < CART_AW; i++) begin
         if (w_size_m1[i]) w_lead = LW'(i + 1);
      end
      for (int i = 0; i < CART_AW; i++) begin
         w_mask_raw[i] = (i < int'(w_lead));
      end
      w_mask = w_mask_raw;
      if (r_cart_size == '0 || w_mask_raw < CART_AW'(MIN_MASK)) w_mask = CART_AW'(MIN_MASK);
   end

   // ROM write port: hold address and data with mem_we until acknowledged.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= 8'd0;
      end else if (w_pop) begin
         r_mem_we   <= 1'b1;
         r_mem_addr <= w_fifo_head[FW-1:8];
         r_mem_data <= w_fifo_head[7:0];
      end else if (r_mem_we && mem_ack) begin
         r_mem_we   <= 1'b0;
      end
   end

   // Target select, overflow flag and cartridge size / mask / loaded bookkeeping.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_sel     <= 1'b0;
         r_overflow    <= 1'b0;
         r_cart_size   <= '0;
         r_cart_loaded <= 1'b0;
         r_cart_mask   <= CART_AW'(MIN_MASK);
      end else begin
         if (w_start) begin
            r_mem_sel  <= (ioctl_index == CART_INDEX);
            r_overflow <= 1'b0;
            if (ioctl_index == CART_INDEX) begin
               r_cart_size   <= '0;
               r_cart_loaded <= 1'b0;
            end
         end
         if (w_drop) r_overflow <= 1'b1;
         if (w_push && r_mem_sel && (w_addr_p1 > r_cart_size)) r_cart_size <= w_addr_p1;
         if (r_state == ST_FINISH && r_mem_sel) begin
            r_cart_mask   <= w_mask;
            r_cart_loaded <= (r_cart_size != '0);
         end
      end
   end

   assign ioctl_wait  = (w_fifo_count != 2'd0);
   assign mem_we      = r_mem_we;
   assign mem_sel     = r_mem_sel;
   assign mem_addr    = r_mem_addr;
   assign mem_data    = r_mem_data;
   assign core_hold   = w_core_hold;
   assign cart_loaded = r_cart_loaded;
   assign cart_size   = r_cart_size;
   assign cart_mask   = r_cart_mask;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_mp1000_cart_loader.sv
// Directed bench for mp1000_cart_loader: download table plus multi-cycle corner sequences.
module tb_mp1000_cart_loader;

   localparam int CART_AW = 14;

   logic               clk_sys = 1'b0;
   logic               reset_n;
   logic               ioctl_download;
   logic [7:0]         ioctl_index;
   logic               ioctl_wr;
   logic [24:0]        ioctl_addr;
   logic [7:0]         ioctl_dout;
   logic               ioctl_wait;
   logic               mem_we;
   logic               mem_sel;
   logic [CART_AW-1:0] mem_addr;
   logic [7:0]         mem_data;
   logic               mem_ack;
   logic               core_hold;
   logic               cart_loaded;
   logic [CART_AW:0]   cart_size;
   logic [CART_AW-1:0] cart_mask;
   logic               overflow;

   mp1000_cart_loader dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_we         (mem_we),
      .mem_sel        (mem_sel),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_ack        (mem_ack),
      .core_hold      (core_hold),
      .cart_loaded    (cart_loaded),
      .cart_size      (cart_size),
      .cart_mask      (cart_mask),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   wr_cnt, wr_err, exp_addr;
   logic exp_sel;
   bit   saw_hold, saw_wait;
   bit   slow_mode = 1'b0;
   logic ack_slow  = 1'b0;
   int   ack_cnt   = 0;

   // Fast memory acks in the same cycle; slow memory acks three cycles after mem_we rises.
   assign mem_ack = slow_mode ? ack_slow : mem_we;

   function automatic logic [7:0] pat(input int a);
      return 8'(a * 7 + (a >>> 8) + 8'h3C);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model and write monitor, evaluated away from the active edge.
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         ack_slow = 1'b0;
         ack_cnt  = 0;
      end else begin
         if (ack_slow) begin
            ack_slow = 1'b0;
         end else if (mem_we) begin
            ack_cnt++;
            if (ack_cnt == 3) begin
               ack_slow = 1'b1;
               ack_cnt  = 0;
            end
         end
         if (mem_we && (slow_mode ? ack_slow : 1'b1)) begin
            wr_cnt++;
            if (mem_sel !== exp_sel || mem_addr !== CART_AW'(exp_addr) || mem_data !== pat(exp_addr))
               wr_err++;
            exp_addr++;
         end
         if (core_hold)  saw_hold = 1'b1;
         if (ioctl_wait) saw_wait = 1'b1;
      end
   end

   // hps_io-like sender: one byte per strobe, holds off while ioctl_wait is high.
   task automatic download(input logic [7:0] idx, input int n, input int stop_at, output int cyc);
      int waitc;
      cyc = 0;
      @(negedge clk_sys);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int a = 0; a < n; a++) begin
         if (a == stop_at) return;
         waitc = 0;
         while (ioctl_wait && waitc < 1000) begin
            @(negedge clk_sys);
            waitc++;
            cyc++;
         end
         if (waitc >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_timeout: ioctl_wait high for %0d cycles, required to drop", waitc);
            break;
         end
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(a);
         ioctl_dout = pat(a);
         @(negedge clk_sys);
         cyc++;
         ioctl_wr = 1'b0;
      end
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      waitc = 0;
      do begin
         @(negedge clk_sys);
         waitc++;
      end while (core_hold && waitc < 1000);
      if (core_hold) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_timeout: core_hold still 1 after %0d cycles, required 0", waitc);
      end
   endtask

   typedef struct {
      logic [7:0]         idx;
      int                 nbytes;
      bit                 slow;
      int                 exp_writes;
      logic               exp_sel;
      logic [CART_AW:0]   exp_size;
      logic [CART_AW-1:0] exp_mask;
      logic               exp_loaded;
      logic               exp_ovf;
      int                 max_cyc;
   } vec_t;

   vec_t vecs [5];
   int   cyc;

   initial begin
      vecs[0] = '{8'd0,  2048, 1'b0,  2048, 1'b0, 15'd0,     14'h07FF, 1'b0, 1'b0, 4098};
      vecs[1] = '{8'd1,  4096, 1'b1,  4096, 1'b1, 15'd4096,  14'h0FFF, 1'b1, 1'b0, 0};
      vecs[2] = '{8'd1,  1500, 1'b0,  1500, 1'b1, 15'd1500,  14'h07FF, 1'b1, 1'b0, 3002};
      vecs[3] = '{8'd1, 20000, 1'b0, 16384, 1'b1, 15'd16384, 14'h3FFF, 1'b1, 1'b1, 0};
      vecs[4] = '{8'd1,     0, 1'b0,     0, 1'b1, 15'd0,     14'h07FF, 1'b0, 1'b0, 0};

      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = 8'd0;
      wr_cnt = 0; wr_err = 0; exp_addr = 0; exp_sel = 1'b0;
      saw_hold = 1'b0; saw_wait = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk_sys);
      check("rst_wait_we_hold", {29'd0, ioctl_wait, mem_we, core_hold}, 32'd0);
      check("rst_sel_loaded_ovf", {29'd0, mem_sel, cart_loaded, overflow}, 32'd0);
      check("rst_addr_data", {10'd0, mem_addr, mem_data}, 32'd0);
      check("rst_cart_size", 32'(cart_size), 32'd0);
      check("rst_cart_mask", 32'(cart_mask), 32'h7FF);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Table of complete downloads.
      for (int i = 0; i < 5; i++) begin
         slow_mode = vecs[i].slow;
         exp_sel   = vecs[i].exp_sel;
         exp_addr  = 0;
         wr_cnt    = 0;
         wr_err    = 0;
         download(vecs[i].idx, vecs[i].nbytes, -1, cyc);
         check($sformatf("v%0d_writes", i), 32'(wr_cnt), 32'(vecs[i].exp_writes));
         check($sformatf("v%0d_write_errors", i), 32'(wr_err), 32'd0);
         check($sformatf("v%0d_mem_sel", i), 32'(mem_sel), 32'(vecs[i].exp_sel));
         check($sformatf("v%0d_cart_size", i), 32'(cart_size), 32'(vecs[i].exp_size));
         check($sformatf("v%0d_cart_mask", i), 32'(cart_mask), 32'(vecs[i].exp_mask));
         check($sformatf("v%0d_cart_loaded", i), 32'(cart_loaded), 32'(vecs[i].exp_loaded));
         check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         if (vecs[i].max_cyc != 0)
            check($sformatf("v%0d_throughput_ok", i), 32'(cyc <= vecs[i].max_cyc), 32'd1);
      end

      // Push latency: a byte accepted at one edge reaches mem_we no earlier than the next.
      slow_mode = 1'b0; exp_sel = 1'b1; exp_addr = 5; wr_cnt = 0; wr_err = 0;
      @(negedge clk_sys);
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'd5;
      ioctl_dout = pat(5);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check("lat_we_not_yet", 32'(mem_we), 32'd0);
      check("lat_wait_high", 32'(ioctl_wait), 32'd1);
      @(negedge clk_sys);
      check("lat_we_high", 32'(mem_we), 32'd1);
      check("lat_addr_data", {10'd0, mem_addr, mem_data}, {10'd0, 14'd5, pat(5)});
      check("lat_wait_low", 32'(ioctl_wait), 32'd0);
      @(negedge clk_sys);
      check("lat_we_dropped", 32'(mem_we), 32'd0);
      ioctl_download = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("lat_writes", 32'(wr_cnt), 32'd1);
      check("lat_cart_size", 32'(cart_size), 32'd6);
      check("lat_cart_loaded", 32'(cart_loaded), 32'd1);

      // Unknown index: nothing happens at all.
      exp_addr = 0; wr_cnt = 0; saw_hold = 1'b0; saw_wait = 1'b0;
      download(8'd3, 100, -1, cyc);
      check("unk_writes", 32'(wr_cnt), 32'd0);
      check("unk_saw_hold", 32'(saw_hold), 32'd0);
      check("unk_saw_wait", 32'(saw_wait), 32'd0);
      check("unk_cart_size_kept", 32'(cart_size), 32'd6);

      // Reset in the middle of a slow cartridge download.
      slow_mode = 1'b1; exp_sel = 1'b1; exp_addr = 0; wr_cnt = 0; wr_err = 0;
      download(8'd1, 8192, 50, cyc);
      check("mid_hold_before", 32'(core_hold), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_we_after_rst", 32'(mem_we), 32'd0);
      check("mid_hold_after_rst", 32'(core_hold), 32'd0);
      check("mid_loaded_after_rst", 32'(cart_loaded), 32'd0);
      check("mid_wait_after_rst", 32'(ioctl_wait), 32'd0);
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Full 8 KB reload after the aborted one.
      slow_mode = 1'b0; exp_sel = 1'b1; exp_addr = 0; wr_cnt = 0; wr_err = 0;
      download(8'd1, 8192, -1, cyc);
      check("re8k_writes", 32'(wr_cnt), 32'd8192);
      check("re8k_write_errors", 32'(wr_err), 32'd0);
      check("re8k_cart_size", 32'(cart_size), 32'd8192);
      check("re8k_cart_mask", 32'(cart_mask), 32'h1FFF);
      check("re8k_cart_loaded", 32'(cart_loaded), 32'd1);
      check("re8k_overflow", 32'(overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
